// File: rtl/ecfs_conduit_fanout.sv
// ecfs_conduit_fanout
// Registered fan-out of one drive-control conduit (PWM trip, sync, enable...)
// to OUTPUT_NUM consumer lanes. The source is glitch-filtered, pipelined, and
// broadcast; each lane has its own registered enable and falls to SAFE_VALUE
// when disabled. A change pulse and saturating change counter are provided for
// diagnostics.
//
// Ports:
//   clk             block clock
//   reset_n         asynchronous active-low reset
//   conduit_input   source signal (DATA_W)
//   out_enable      per-lane enable, bit i controls lane i (registered once)
//   count_clear     synchronous clear of change_count
//   conduit_output  lane i at bits [i*DATA_W +: DATA_W]
//   change_pulse    one-cycle pulse after the pipeline output changes
//   change_count    saturating 16-bit count of accepted changes
module ecfs_conduit_fanout #(
    parameter int          DATA_W      = 1,
    parameter int          OUTPUT_NUM  = 2,
    parameter int          FILTER_LEN  = 0,
    parameter int          PIPE_STAGES = 1,
    parameter logic [31:0] SAFE_VALUE  = 32'h0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [DATA_W-1:0]            conduit_input,
    input  logic [OUTPUT_NUM-1:0]        out_enable,
    input  logic                         count_clear,
    output logic [OUTPUT_NUM*DATA_W-1:0] conduit_output,
    output logic                         change_pulse,
    output logic [15:0]                  change_count
);

    localparam logic [DATA_W-1:0] SAFE = SAFE_VALUE[DATA_W-1:0];

    logic [DATA_W-1:0] accepted;
    logic [DATA_W-1:0] pipe_out;

    generate
        if (FILTER_LEN == 0) begin : g_bypass
            assign accepted = conduit_input;
        end else begin : g_filter
            localparam int CW = ($clog2(FILTER_LEN + 1) < 1) ? 1 : $clog2(FILTER_LEN + 1);
            localparam logic [CW-1:0] TERM = CW'(FILTER_LEN);

            logic [DATA_W-1:0] cand_q, cand_d;
            logic [DATA_W-1:0] acc_q, acc_d;
            logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;

            // The count covers consecutive edges seeing the same non-accepted
            // value; a new value restarts at 1 because this edge already counts.
            always_comb begin
                cand_d  = conduit_input;
                acc_d   = acc_q;
                cnt_d   = '0;
                cnt_inc = (conduit_input == cand_q) ? cnt_q + CW'(1) : CW'(1);
                if (conduit_input != acc_q) begin
                    if (cnt_inc >= TERM) begin
                        acc_d = conduit_input;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cand_q <= SAFE;
                    acc_q  <= SAFE;
                    cnt_q  <= '0;
                end else begin
                    cand_q <= cand_d;
                    acc_q  <= acc_d;
                    cnt_q  <= cnt_d;
                end
            end

            assign accepted = acc_q;
        end
    endgenerate

    generate
        if (PIPE_STAGES == 0) begin : g_nopipe
            assign pipe_out = accepted;
        end else begin : g_pipe
            logic [DATA_W-1:0] stage_q [PIPE_STAGES];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < PIPE_STAGES; i++) begin
                        stage_q[i] <= SAFE;
                    end
                end else begin
                    stage_q[0] <= accepted;
                    for (int i = 1; i < PIPE_STAGES; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign pipe_out = stage_q[PIPE_STAGES-1];
        end
    endgenerate

    logic [OUTPUT_NUM-1:0] en_q;
    logic [DATA_W-1:0]     prev_q;
    logic                  pulse_q;
    logic [15:0]           count_q, count_d;
    logic                  change_ev;

    assign change_ev = (pipe_out != prev_q);

    // A clear coincident with a change keeps that change counted.
    always_comb begin
        count_d = count_q;
        if (count_clear) begin
            count_d = change_ev ? 16'd1 : 16'd0;
        end else if (change_ev && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q    <= '0;
            prev_q  <= SAFE;
            pulse_q <= 1'b0;
            count_q <= 16'd0;
        end else begin
            en_q    <= out_enable;
            prev_q  <= pipe_out;
            pulse_q <= change_ev;
            count_q <= count_d;
        end
    end

    generate
        for (genvar i = 0; i < OUTPUT_NUM; i++) begin : g_lane
            assign conduit_output[i*DATA_W +: DATA_W] = en_q[i] ? pipe_out : SAFE;
        end
    endgenerate

    assign change_pulse = pulse_q;
    assign change_count = count_q;

endmodule

// File: tb/tb_ecfs_conduit_fanout.sv
module tb_ecfs_conduit_fanout;

    localparam int DW = 8;
    localparam int ON = 4;
    localparam int FL = 3;
    localparam int PS = 2;
    localparam logic [7:0] SAFE = 8'hA5;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    // main instance: filtered, pipelined, randomized and scoreboarded
    logic [DW-1:0]    din;
    logic [ON-1:0]    en;
    logic             clr;
    logic [ON*DW-1:0] dout;
    logic             pulse;
    logic [15:0]      cnt;

    // second instance: unfiltered, one stage, used for counter boundaries
    logic        c_din;
    logic [1:0]  c_en;
    logic        c_clr;
    logic [1:0]  c_dout;
    logic        c_pulse;
    logic [15:0] c_cnt;

    ecfs_conduit_fanout #(
        .DATA_W(DW), .OUTPUT_NUM(ON), .FILTER_LEN(FL), .PIPE_STAGES(PS),
        .SAFE_VALUE(32'(SAFE))
    ) dut (
        .clk(clk), .reset_n(reset_n), .conduit_input(din), .out_enable(en),
        .count_clear(clr), .conduit_output(dout), .change_pulse(pulse),
        .change_count(cnt)
    );

    ecfs_conduit_fanout #(
        .DATA_W(1), .OUTPUT_NUM(2), .FILTER_LEN(0), .PIPE_STAGES(1),
        .SAFE_VALUE(32'h0)
    ) dut_c (
        .clk(clk), .reset_n(reset_n), .conduit_input(c_din), .out_enable(c_en),
        .count_clear(c_clr), .conduit_output(c_dout), .change_pulse(c_pulse),
        .change_count(c_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] lanes;
        logic        pulse;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    // Reference model: a value is accepted once the last FL samples are all
    // that value and it differs from what is accepted; the pipeline output is
    // the accepted value PS edges ago.
    logic [7:0]  m_hist[$];
    logic [7:0]  m_acc;
    logic [7:0]  m_acc_tr[$];
    logic [7:0]  m_po, m_po_prev;
    logic [15:0] m_cnt;
    int          hold_left;

    task automatic model_reset();
        m_hist.delete();
        m_acc = SAFE;
        m_acc_tr.delete();
        for (int i = 0; i < PS; i++) m_acc_tr.push_back(SAFE);
        m_po      = SAFE;
        m_po_prev = SAFE;
        m_cnt     = 16'd0;
    endtask

    task automatic model_edge();
        exp_t       e;
        logic       ev;
        logic       same;
        logic [7:0] po_new;
        m_hist.push_back(din);
        if (m_hist.size() > FL) void'(m_hist.pop_front());
        if (m_hist.size() == FL) begin
            same = 1'b1;
            foreach (m_hist[k]) if (m_hist[k] != din) same = 1'b0;
            if (same && din != m_acc) m_acc = din;
        end
        m_acc_tr.push_back(m_acc);
        po_new = m_acc_tr.pop_front();
        ev = (m_po != m_po_prev);
        m_po_prev = m_po;
        m_po      = po_new;
        if (clr) m_cnt = ev ? 16'd1 : 16'd0;
        else if (ev && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        for (int i = 0; i < ON; i++) e.lanes[i*8 +: 8] = en[i] ? po_new : SAFE;
        e.pulse = ev;
        e.cnt   = m_cnt;
        sb.push_back(e);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        if (hold_left == 0) begin
            case ($urandom_range(0, 3))
                0: din = 8'h3C;
                1: din = SAFE;
                2: din = 8'h00;
                default: din = 8'($urandom);
            endcase
            hold_left = $urandom_range(1, 5);
        end
        hold_left--;
        if ($urandom_range(0, 3) == 0) en = 4'($urandom);
        clr = ($urandom_range(0, 19) == 0);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_lanes", dout, {ON{SAFE}});
        check("rst_pulse", 32'(pulse), 32'h0);
        check("rst_count", 32'(cnt), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        model_reset();
    endtask

    // monitor: compares whatever the driver queued for this cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("lanes", dout, e.lanes);
                check("pulse", 32'(pulse), 32'(e.pulse));
                check("count", 32'(cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        din = SAFE; en = '0; clr = 1'b0; hold_left = 0;
        c_din = 1'b1; c_en = 2'b00; c_clr = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("init_lanes", dout, {ON{SAFE}});
        check("init_count", 32'(cnt), 32'h0);
        check("init_c_lanes", 32'(c_dout), 32'h0);
        check("init_c_count", 32'(c_cnt), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
        model_reset();

        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 699) mid_reset();
            cycle();
        end
        @(negedge clk);
        #2;
        check("sb_drain", 32'(sb.size()), 32'h0);

        // counter boundaries on the unfiltered instance
        reset_n = 1'b0; c_din = 1'b1; c_en = 2'b00; c_clr = 1'b0;
        #1;
        check("c_rst_lanes", 32'(c_dout), 32'h0);
        check("c_rst_pulse", 32'(c_pulse), 32'h0);
        check("c_rst_count", 32'(c_cnt), 32'h0);
        @(posedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1; c_en = 2'b11;
        @(posedge clk); #1;
        check("c_lanes_on", 32'(c_dout), 32'h3);
        check("c_pulse_e1", 32'(c_pulse), 32'h0);
        @(posedge clk); #1;
        check("c_pulse_e2", 32'(c_pulse), 32'h1);
        check("c_count_e2", 32'(c_cnt), 32'h1);
        @(posedge clk); #1;
        check("c_pulse_e3", 32'(c_pulse), 32'h0);
        check("c_count_e3", 32'(c_cnt), 32'h1);

        for (int i = 0; i < 65540; i++) begin
            c_din = ~c_din;
            @(posedge clk); #1;
            if (i == 99) begin
                check("c_count_mid", 32'(c_cnt), 32'd100);
                check("c_pulse_mid", 32'(c_pulse), 32'h1);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        check("c_count_sat", 32'(c_cnt), 32'hFFFF);
        check("c_pulse_idle", 32'(c_pulse), 32'h0);

        c_clr = 1'b1;
        @(posedge clk); #1;
        check("c_clear", 32'(c_cnt), 32'h0);
        c_clr = 1'b0;

        c_din = ~c_din;
        @(posedge clk); #1;
        c_clr = 1'b1;
        @(posedge clk); #1;
        check("c_clear_chg", 32'(c_cnt), 32'h1);
        check("c_clear_pulse", 32'(c_pulse), 32'h1);
        c_clr = 1'b0;
        c_en = 2'b01;
        @(posedge clk); #1;
        check("c_count_hold", 32'(c_cnt), 32'h1);
        check("c_lane_dis", 32'(c_dout), 32'({1'b0, c_din}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
